pipelined_adder: RTL and testbench



---
 rtl/dsd_pkg.sv | 9 +
 rtl/adder_stage.sv | 19 +
 rtl/full_adder.sv | 11 +
 rtl/pipelined_adder.sv | 81 ++++++++
 tb/tb_pipelined_adder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsd_pkg.sv
// dsd_pkg: shared datapath constants and elaboration-time parameter checks.
package dsd_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic bit seg_params_ok(input int width, input int seg);
      return seg >= 1 && width % seg == 0;
   endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: SEG-bit ripple segment adder; cm is the carry into the segment MSB.
module adder_stage #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           cm
);
   logic [SEG:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < SEG; i++) begin : g_bit
      full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
   end
   assign co = c[SEG];
   assign cm = c[SEG-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into WIDTH/SEG carry-registered stages.
module pipelined_adder
   import dsd_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / SEG;
   logic en;
   logic ovf_q;
   if (!seg_params_ok(WIDTH, SEG)) begin : g_chk
      $fatal(1, "pipelined_adder: WIDTH must be a positive multiple of SEG");
   end
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   // Stage k: pa/pb hold operand segments k.. (upper ones still waiting), s_q the finished low sum.
   for (genvar k = 0; k < STAGES; k++) begin : g
      logic [(STAGES-k)*SEG-1:0] pa;
      logic [(STAGES-k)*SEG-1:0] pb;
      logic [(k+1)*SEG-1:0]      s_q;
      logic [SEG-1:0]            s;
      logic                      ci, co, cm, c_q, v_q;
      adder_stage #(.SEG(SEG)) u_stage (
         .a(pa[SEG-1:0]), .b(pb[SEG-1:0]), .ci(ci), .s(s), .co(co), .cm(cm)
      );
      if (k == 0) begin : g_in
         assign pa = a;
         assign pb = sub == OP_SUB ? ~b : b;
         assign ci = sub == OP_SUB ? 1'b1 : cin;
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (en) begin
               s_q <= s;
               c_q <= co;
               v_q <= in_valid;
            end
      end else begin : g_mid
         assign ci = g[k-1].c_q;
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               pa  <= '0;
               pb  <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (en) begin
               pa  <= g[k-1].pa[(STAGES-k+1)*SEG-1:SEG];
               pb  <= g[k-1].pb[(STAGES-k+1)*SEG-1:SEG];
               s_q <= {s, g[k-1].s_q};
               c_q <= co;
               v_q <= g[k-1].v_q;
            end
      end
      if (k == STAGES - 1) begin : g_ovf
         always_ff @(posedge clk or posedge rst)
            if (rst) ovf_q <= 1'b0;
            else if (en) ovf_q <= cm ^ co;
      end
   end
   assign sum       = g[STAGES-1].s_q;
   assign cout      = g[STAGES-1].c_q;
   assign out_valid = g[STAGES-1].v_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed, streaming, stall and reset scenarios against an arithmetic model.
module tb_pipelined_adder;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, cout, ovf;
   logic [31:0] sum;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   // {ovf, cout, sum} from signed/unsigned integer arithmetic
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic s, input logic c);
      longint ux, uy, sx, sy, r;
      logic   co, v;
      logic [31:0] res;
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         co  = ux >= uy;
         r   = sx - sy;
         res = x - y;
      end else begin
         co  = (ux + uy + longint'(c)) >= 64'sh1_0000_0000;
         r   = sx + sy + longint'(c);
         res = x + y + {31'd0, c};
      end
      v = r > 64'sd2147483647 || r < -64'sd2147483648;
      return {v, co, res};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, sum, cout, ovf} !== 35'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {out_valid, sum, cout, ovf});
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      logic [31:0] ta[5]   = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'h12345678};
      logic [31:0] tb[5]   = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'h11111111};
      logic        ts[5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic        tc[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] tsum[5] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h2345678A};
      logic        tco[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        tov[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         int n;
         a = ta[i];
         b = tb[i];
         sub = ts[i];
         cin = tc[i];
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
         end
         checks++;
         if (n !== 4) begin
            failures++;
            $display("FAIL directed_latency[%0d] got=%0d want=4", i, n);
         end
         checks++;
         if ({sum, cout, ovf} !== {tsum[i], tco[i], tov[i]}) begin
            failures++;
            $display("FAIL directed_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, sum, cout, ovf, tsum[i], tco[i], tov[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stream(input bit stall);
      logic [31:0] oa[16], ob[16];
      logic        os[16], oc[16];
      logic [33:0] exp_q[$];
      logic [33:0] exp;
      logic [34:0] held;
      bit          hold;
      bit          exp_rdy;
      int          sent, got, last;
      hold = 1'b0;
      sent = 0;
      got = 0;
      last = stall ? 24 : 20;
      for (int i = 0; i < 16; i++) begin
         oa[i] = $urandom;
         ob[i] = $urandom;
         os[i] = 1'($urandom_range(0, 1));
         oc[i] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 60 && got < 16; c++) begin
         in_valid = sent < 16;
         if (sent < 16) begin
            a = oa[sent];
            b = ob[sent];
            sub = os[sent];
            cin = oc[sent];
         end
         out_ready = !(stall && c >= 6 && c <= 9);
         exp_rdy = !(stall && c >= 6 && c <= 9);
         #1;
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL stream_in_ready[c=%0d] got=%b want=%b", c, in_ready, exp_rdy);
         end
         checks++;
         if (out_valid !== (c >= 4 && c < last)) begin
            failures++;
            $display("FAIL stream_out_valid[c=%0d] got=%b want=%b", c, out_valid, c >= 4 && c < last);
         end
         if (hold) begin
            checks++;
            if ({out_valid, sum, cout, ovf} !== held) begin
               failures++;
               $display("FAIL stall_hold[c=%0d] got=%h want=%h", c, {out_valid, sum, cout, ovf}, held);
            end
         end
         hold = out_valid && !out_ready;
         held = {out_valid, sum, cout, ovf};
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra[c=%0d] got sum=%h want no result", c, sum);
            end else begin
               exp = exp_q.pop_front();
               if ({ovf, cout, sum} !== exp) begin
                  failures++;
                  $display("FAIL stream_result[c=%0d] got=%h want=%h", c, {ovf, cout, sum}, exp);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub, cin));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got !== 16 || sent !== 16) begin
         failures++;
         $display("FAIL stream_count got=%0d/%0d want=16/16", got, sent);
      end
   endtask

   task automatic test_reset_inflight;
      logic [33:0] exp;
      int n;
      out_ready = 1'b1;
      in_valid = 1'b1;
      sub = 1'b0;
      cin = 1'b0;
      a = 32'h11111111;
      b = 32'h22222222;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b1 || sum !== 32'h33333333) begin
         failures++;
         $display("FAIL preflight got valid=%b sum=%h want valid=1 sum=33333333", out_valid, sum);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, sum, cout, ovf} !== 35'd0) begin
         failures++;
         $display("FAIL async_reset got=%h want=0", {out_valid, sum, cout, ovf});
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_in_ready got=%b want=1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'h01020304;
      cin = 1'b1;
      in_valid = 1'b1;
      exp = model(a, b, sub, cin);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL post_reset_latency got=%0d want=4", n);
      end
      checks++;
      if ({ovf, cout, sum} !== exp) begin
         failures++;
         $display("FAIL post_reset_result got=%h want=%h", {ovf, cout, sum}, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_drain got=%b want=0", out_valid);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_stream(1'b0);
      test_stream(1'b1);
      test_reset_inflight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
